// File: rtl/gb_mbc1.sv
// gb_mbc1: MBC1 memory bank controller on the Game Boy cartridge bus.
// Decodes cartridge cycles and keeps the MBC1 banking registers.
// Each ROM or RAM access goes to the backing store through a req/ready
// handshake. One cartridge write edge that arrives while a store request
// is in flight is held and serviced when the controller returns to idle.
module gb_mbc1 #(
  parameter int ROM_AW = 21,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       i_cart_addr,
  input  logic              i_cart_rd,
  input  logic              i_cart_wr,
  input  logic [7:0]        i_cart_di,
  output logic [7:0]        o_cart_do,
  input  logic [6:0]        i_rom_mask,
  input  logic [1:0]        i_ram_mask,
  input  logic              i_ram_present,
  output logic [ROM_AW-1:0] o_mem_addr,
  output logic              o_mem_ram,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [7:0]        o_mem_dout,
  input  logic [7:0]        i_mem_din,
  input  logic              i_mem_ready,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  // Full 21-bit ROM byte address for a CPU address and the current banking state.
  function automatic logic [20:0] f_rom_addr(
    input logic [15:0] addr,
    input logic [4:0]  bank1,
    input logic [1:0]  bank2,
    input logic        mode,
    input logic [6:0]  mask
  );
    logic [6:0] bank;
    if (addr[14]) begin
      bank = {bank2, bank1};
    end else if (mode) begin
      bank = {bank2, 5'b00000};
    end else begin
      bank = 7'd0;
    end
    return {bank & mask, addr[13:0]};
  endfunction

  // Full 15-bit cart RAM byte address for an A000-BFFF access.
  function automatic logic [14:0] f_ram_addr(
    input logic [12:0] addr,
    input logic [1:0]  bank2,
    input logic        mode,
    input logic [1:0]  mask
  );
    logic [1:0] rbank;
    rbank = (mode ? bank2 : 2'b00) & mask;
    return {rbank, addr};
  endfunction

  // Registers
  state_t              r_state;
  logic                r_ram_en;
  logic [4:0]          r_bank1;
  logic [1:0]          r_bank2;
  logic                r_mode;
  logic [7:0]          r_cart_do;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ROM_AW-1:0]   r_mem_addr;
  logic                r_mem_ram;
  logic [7:0]          r_mem_dout;
  logic                r_busy;
  logic [15:0]         r_last_addr;
  logic                r_last_valid;
  logic                r_wr_prev;
  logic                r_pend;
  logic [15:0]         r_pend_addr;
  logic [7:0]          r_pend_data;

  // Next-state values
  state_t              w_state_nxt;
  logic                w_ram_en_nxt;
  logic [4:0]          w_bank1_nxt;
  logic [1:0]          w_bank2_nxt;
  logic                w_mode_nxt;
  logic [7:0]          w_cart_do_nxt;
  logic                w_mem_rd_nxt;
  logic                w_mem_wr_nxt;
  logic [ROM_AW-1:0]   w_mem_addr_nxt;
  logic                w_mem_ram_nxt;
  logic [7:0]          w_mem_dout_nxt;
  logic [15:0]         w_last_addr_nxt;
  logic                w_last_valid_nxt;
  logic                w_pend_nxt;
  logic [15:0]         w_pend_addr_nxt;
  logic [7:0]          w_pend_data_nxt;

  // Decode helpers
  logic                w_wr_edge;
  logic                w_ram_on;
  logic                w_svc;
  logic [15:0]         w_svc_addr;
  logic [7:0]          w_svc_data;
  logic                w_svc_is_ram;
  logic                w_rd_new;
  logic                w_rd_is_ram;
  logic                w_pend_take;
  logic [ROM_AW-1:0]   w_rom_addr_rd;
  logic [ROM_AW-1:0]   w_ram_addr_rd;
  logic [ROM_AW-1:0]   w_ram_addr_svc;

  assign w_wr_edge    = i_cart_wr & ~r_wr_prev;
  assign w_ram_on     = r_ram_en & i_ram_present;
  // A held write takes priority over a fresh edge; the fresh edge is then held.
  assign w_svc        = r_pend | w_wr_edge;
  assign w_svc_addr   = r_pend ? r_pend_addr : i_cart_addr;
  assign w_svc_data   = r_pend ? r_pend_data : i_cart_di;
  assign w_svc_is_ram = (w_svc_addr[15:13] == 3'b101);
  assign w_rd_is_ram  = (i_cart_addr[15:13] == 3'b101);
  assign w_rd_new     = i_cart_rd & (~r_last_valid | (i_cart_addr != r_last_addr));
  assign w_pend_take  = w_wr_edge & ~r_pend;

  assign w_rom_addr_rd  = ROM_AW'(f_rom_addr(i_cart_addr, r_bank1, r_bank2, r_mode, i_rom_mask));
  assign w_ram_addr_rd  = ROM_AW'(RAM_AW'(f_ram_addr(i_cart_addr[12:0], r_bank2, r_mode, i_ram_mask)));
  assign w_ram_addr_svc = ROM_AW'(RAM_AW'(f_ram_addr(w_svc_addr[12:0], r_bank2, r_mode, i_ram_mask)));

  // Next-state and next-output logic for the request FSM and banking registers.
  always_comb begin
    w_state_nxt      = r_state;
    w_ram_en_nxt     = r_ram_en;
    w_bank1_nxt      = r_bank1;
    w_bank2_nxt      = r_bank2;
    w_mode_nxt       = r_mode;
    w_cart_do_nxt    = r_cart_do;
    w_mem_rd_nxt     = r_mem_rd;
    w_mem_wr_nxt     = r_mem_wr;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_ram_nxt    = r_mem_ram;
    w_mem_dout_nxt   = r_mem_dout;
    w_last_addr_nxt  = r_last_addr;
    w_last_valid_nxt = r_last_valid;
    w_pend_nxt       = r_pend;
    w_pend_addr_nxt  = r_pend_addr;
    w_pend_data_nxt  = r_pend_data;

    case (r_state)
      ST_IDLE: begin
        if (w_svc) begin
          if (r_pend) begin
            w_pend_nxt      = w_wr_edge;
            w_pend_addr_nxt = i_cart_addr;
            w_pend_data_nxt = i_cart_di;
          end else begin
            w_pend_nxt = 1'b0;
          end
          if (!w_svc_addr[15]) begin
            // Banking register write; forces the next read to re-fetch.
            w_last_valid_nxt = 1'b0;
            case (w_svc_addr[14:13])
              2'b00:   w_ram_en_nxt = (w_svc_data[3:0] == 4'hA);
              2'b01:   w_bank1_nxt  = (w_svc_data[4:0] == 5'd0) ? 5'd1 : w_svc_data[4:0];
              2'b10:   w_bank2_nxt  = w_svc_data[1:0];
              2'b11:   w_mode_nxt   = w_svc_data[0];
              default: w_mode_nxt   = r_mode;
            endcase
          end else if (w_svc_is_ram && w_ram_on) begin
            w_state_nxt    = ST_WR_WAIT;
            w_mem_wr_nxt   = 1'b1;
            w_mem_ram_nxt  = 1'b1;
            w_mem_addr_nxt = w_ram_addr_svc;
            w_mem_dout_nxt = w_svc_data;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_rd_new) begin
          if (!i_cart_addr[15]) begin
            w_state_nxt     = ST_RD_WAIT;
            w_mem_rd_nxt    = 1'b1;
            w_mem_ram_nxt   = 1'b0;
            w_mem_addr_nxt  = w_rom_addr_rd;
            w_last_addr_nxt = i_cart_addr;
          end else if (w_rd_is_ram && w_ram_on) begin
            w_state_nxt     = ST_RD_WAIT;
            w_mem_rd_nxt    = 1'b1;
            w_mem_ram_nxt   = 1'b1;
            w_mem_addr_nxt  = w_ram_addr_rd;
            w_last_addr_nxt = i_cart_addr;
          end else if (w_rd_is_ram) begin
            // Disabled RAM reads back as open bus without touching the store.
            w_cart_do_nxt    = 8'hFF;
            w_last_addr_nxt  = i_cart_addr;
            w_last_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RD_WAIT: begin
        if (w_pend_take) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = i_cart_addr;
          w_pend_data_nxt = i_cart_di;
        end else begin
          w_pend_nxt = r_pend;
        end
        if (i_mem_ready) begin
          w_cart_do_nxt    = i_mem_din;
          w_mem_rd_nxt     = 1'b0;
          w_last_valid_nxt = 1'b1;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_mem_rd_nxt = 1'b1;
        end
      end

      ST_WR_WAIT: begin
        if (w_pend_take) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = i_cart_addr;
          w_pend_data_nxt = i_cart_di;
        end else begin
          w_pend_nxt = r_pend;
        end
        if (i_mem_ready) begin
          w_mem_wr_nxt     = 1'b0;
          w_last_valid_nxt = 1'b0;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_mem_wr_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_mem_rd_nxt = 1'b0;
        w_mem_wr_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Banking registers, registered outputs and read/write tracking.
  always_ff @(posedge clk) begin
    r_wr_prev <= i_cart_wr;
    if (reset) begin
      r_ram_en     <= 1'b0;
      r_bank1      <= 5'd1;
      r_bank2      <= 2'd0;
      r_mode       <= 1'b0;
      r_cart_do    <= 8'hFF;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_ram    <= 1'b0;
      r_mem_dout   <= 8'h00;
      r_busy       <= 1'b0;
      r_last_addr  <= 16'hFFFF;
      r_last_valid <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_addr  <= 16'h0000;
      r_pend_data  <= 8'h00;
    end else begin
      r_ram_en     <= w_ram_en_nxt;
      r_bank1      <= w_bank1_nxt;
      r_bank2      <= w_bank2_nxt;
      r_mode       <= w_mode_nxt;
      r_cart_do    <= w_cart_do_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_ram    <= w_mem_ram_nxt;
      r_mem_dout   <= w_mem_dout_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_last_addr  <= w_last_addr_nxt;
      r_last_valid <= w_last_valid_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_pend_data  <= w_pend_data_nxt;
    end
  end

  assign o_cart_do  = r_cart_do;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_ram  = r_mem_ram;
  assign o_mem_rd   = r_mem_rd;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_dout = r_mem_dout;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_gb_mbc1.sv
// Directed testbench for gb_mbc1 with hand-computed expected values.
`timescale 1ns/1ps
module tb_gb_mbc1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cart_addr;
  logic        cart_rd;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  cart_do;
  logic [6:0]  rom_mask;
  logic [1:0]  ram_mask;
  logic        ram_present;
  logic [20:0] mem_addr;
  logic        mem_ram;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  gb_mbc1 #(.ROM_AW(21), .RAM_AW(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cart_addr  (cart_addr),
    .i_cart_rd    (cart_rd),
    .i_cart_wr    (cart_wr),
    .i_cart_di    (cart_di),
    .o_cart_do    (cart_do),
    .i_rom_mask   (rom_mask),
    .i_ram_mask   (ram_mask),
    .i_ram_present(ram_present),
    .o_mem_addr   (mem_addr),
    .o_mem_ram    (mem_ram),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_mem_dout   (mem_dout),
    .i_mem_din    (mem_din),
    .i_mem_ready  (mem_ready),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    cart_addr = a;
    cart_di   = d;
    cart_wr   = 1'b1;
    tick(1);
    cart_wr   = 1'b0;
    tick(1);
  endtask

  task automatic ready_pulse(input logic [7:0] d);
    mem_din   = d;
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic prev;
    reset = 1'b1; cart_addr = 16'h0000; cart_rd = 1'b0; cart_wr = 1'b0;
    cart_di = 8'h00; rom_mask = 7'h7F; ram_mask = 2'd3; ram_present = 1'b1;
    mem_din = 8'h00; mem_ready = 1'b0;
    tick(2);
    chk("rst_cart_do", 32'(cart_do), 32'h0000_00FF);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_ram_dout", {23'd0, mem_ram, mem_dout}, 32'h0);
    reset = 1'b0;

    // First ROM read, bank 1 after reset
    cart_addr = 16'h4000; cart_rd = 1'b1;
    tick(1);
    chk("rd4000_mem_rd", 32'(mem_rd), 32'h1);
    chk("rd4000_addr", 32'(mem_addr), 32'h0000_4000);
    chk("rd4000_ram", 32'(mem_ram), 32'h0);
    chk("rd4000_busy", 32'(busy), 32'h1);
    tick(2);
    chk("rd4000_hold", 32'(mem_rd), 32'h1);
    ready_pulse(8'h5A);
    chk("rd4000_do", 32'(cart_do), 32'h0000_005A);
    chk("rd4000_rd_low", 32'(mem_rd), 32'h0);
    chk("rd4000_idle", 32'(busy), 32'h0);
    cart_rd = 1'b0;

    // bank1 zero maps to 1, then 1F, then bank2=3
    reg_write(16'h2000, 8'h00);
    cart_addr = 16'h4123; cart_rd = 1'b1; tick(1);
    chk("bank1_zero", 32'(mem_addr), 32'h0000_4123);
    ready_pulse(8'h11); cart_rd = 1'b0;
    reg_write(16'h2000, 8'h1F);
    cart_addr = 16'h4123; cart_rd = 1'b1; tick(1);
    chk("bank1_1f", 32'(mem_addr), 32'h0007_C123);
    ready_pulse(8'h22); cart_rd = 1'b0;
    reg_write(16'h4000, 8'h03);
    cart_addr = 16'h4123; cart_rd = 1'b1; tick(1);
    chk("bank2_3", 32'(mem_addr), 32'h001F_C123);
    ready_pulse(8'h33); cart_rd = 1'b0;

    // Mode 1 lower ROM window, with and without mask
    reg_write(16'h4000, 8'h02);
    reg_write(16'h6000, 8'h01);
    cart_addr = 16'h0010; cart_rd = 1'b1; tick(1);
    chk("mode1_low", 32'(mem_addr), 32'h0010_0010);
    ready_pulse(8'h44); cart_rd = 1'b0;
    rom_mask = 7'h1F;
    reg_write(16'h6000, 8'h01);
    cart_addr = 16'h0010; cart_rd = 1'b1; tick(1);
    chk("mode1_masked", 32'(mem_addr), 32'h0000_0010);
    ready_pulse(8'h55); cart_rd = 1'b0;
    rom_mask = 7'h7F;

    // RAM disabled read returns FF without a request
    cart_addr = 16'hA000; cart_rd = 1'b1; tick(1);
    chk("ramoff_no_rd", 32'(mem_rd), 32'h0);
    chk("ramoff_busy", 32'(busy), 32'h0);
    chk("ramoff_do", 32'(cart_do), 32'h0000_00FF);
    cart_rd = 1'b0;

    // Enable RAM, mode 0, read then write same byte with rd held
    reg_write(16'h0000, 8'h0A);
    reg_write(16'h6000, 8'h00);
    cart_addr = 16'hA005; cart_rd = 1'b1; tick(1);
    chk("ramrd_mem_rd", 32'(mem_rd), 32'h1);
    chk("ramrd_addr", {10'd0, mem_ram, mem_addr}, 32'h0020_0005);
    ready_pulse(8'h44);
    chk("ramrd_do", 32'(cart_do), 32'h0000_0044);
    tick(2);
    chk("ramrd_no_refetch", 32'(mem_rd), 32'h0);
    cart_di = 8'h77; cart_wr = 1'b1; tick(1);
    chk("ramwr_mem_wr", 32'(mem_wr), 32'h1);
    chk("ramwr_rd_blocked", 32'(mem_rd), 32'h0);
    chk("ramwr_addr", {10'd0, mem_ram, mem_addr}, 32'h0020_0005);
    chk("ramwr_dout", 32'(mem_dout), 32'h0000_0077);
    cart_wr = 1'b0;
    ready_pulse(8'h00);
    chk("ramwr_done", {30'd0, mem_wr, busy}, 32'h0);
    tick(1);
    chk("ramwr_refetch", 32'(mem_rd), 32'h1);
    chk("ramwr_refetch_addr", 32'(mem_addr), 32'h0000_0005);
    ready_pulse(8'h77);
    chk("ramwr_refetch_do", 32'(cart_do), 32'h0000_0077);
    cart_rd = 1'b0;

    // RAM bank with mode 1, bank2=3, ram_mask=1
    reg_write(16'h6000, 8'h01);
    reg_write(16'h4000, 8'h03);
    ram_mask = 2'd1;
    cart_addr = 16'hA010; cart_di = 8'h5E; cart_wr = 1'b1; tick(1);
    chk("rambank_wr", 32'(mem_wr), 32'h1);
    chk("rambank_addr", 32'(mem_addr), 32'h0000_2010);
    cart_wr = 1'b0;
    ready_pulse(8'h00);
    chk("rambank_idle", 32'(busy), 32'h0);

    // Held read at a fixed address issues exactly one request
    cart_addr = 16'h4200; cart_rd = 1'b1; mem_din = 8'h66;
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_rd && !prev) cnt++;
      prev = mem_rd;
      mem_ready = mem_rd;
    end
    mem_ready = 1'b0;
    chk("hold_one_rd", 32'(cnt), 32'd1);
    chk("hold_do", 32'(cart_do), 32'h0000_0066);
    cart_rd = 1'b0;

    // Read outside mapped windows does nothing
    cart_addr = 16'hC000; cart_rd = 1'b1; tick(2);
    chk("outside_no_rd", {30'd0, mem_rd, busy}, 32'h0);
    chk("outside_do", 32'(cart_do), 32'h0000_0066);
    cart_rd = 1'b0;

    // Write edges during RD_WAIT: first held, second dropped
    cart_addr = 16'h4000; cart_rd = 1'b1; tick(1);
    chk("pend_rd", 32'(mem_addr), 32'h001F_C000);
    cart_rd = 1'b0;
    cart_addr = 16'h2000; cart_di = 8'h20; cart_wr = 1'b1; tick(1); cart_wr = 1'b0; tick(1);
    chk("pend_addr_held", 32'(mem_addr), 32'h001F_C000);
    chk("pend_rd_held", 32'(mem_rd), 32'h1);
    cart_di = 8'h05; cart_wr = 1'b1; tick(1); cart_wr = 1'b0; tick(1);
    ready_pulse(8'h9C);
    chk("pend_do", 32'(cart_do), 32'h0000_009C);
    tick(1);
    cart_addr = 16'h4123; cart_rd = 1'b1; tick(1);
    chk("pend_bank1", 32'(mem_addr), 32'h0018_4123);
    ready_pulse(8'h00);

    // Address change during RD_WAIT completes old request then re-issues
    cart_addr = 16'h4000; tick(1);
    chk("addrchg_first", 32'(mem_addr), 32'h0018_4000);
    cart_addr = 16'h4001; tick(1);
    chk("addrchg_held", 32'(mem_addr), 32'h0018_4000);
    ready_pulse(8'h00);
    tick(1);
    chk("addrchg_reissue", {10'd0, mem_rd, mem_addr}, 32'h0038_4001);
    ready_pulse(8'h00);
    cart_rd = 1'b0;

    // Reset during RD_WAIT
    cart_addr = 16'h4300; cart_rd = 1'b1; tick(1);
    chk("rstmid_rd", 32'(mem_rd), 32'h1);
    reset = 1'b1; tick(1);
    chk("rstmid_rd_low", 32'(mem_rd), 32'h0);
    chk("rstmid_do", 32'(cart_do), 32'h0000_00FF);
    chk("rstmid_busy", 32'(busy), 32'h0);
    reset = 1'b0; cart_rd = 1'b0;
    ready_pulse(8'hAB);
    chk("late_ready_do", 32'(cart_do), 32'h0000_00FF);
    chk("late_ready_busy", 32'(busy), 32'h0);
    cart_addr = 16'h4000; cart_rd = 1'b1; tick(1);
    chk("post_rst_bank", 32'(mem_addr), 32'h0000_4000);
    ready_pulse(8'h00);
    cart_rd = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
